sort_frame_sink: RTL and testbench
==================================

Name: sort_frame_sink

Overview:
- Receiving end of the sorter output handshake (`sort_val`/`sort_rdy`/`sort_data`).
- Accepts fixed-length frames of sorted words and buffers them in a small FIFO, then forwards them downstream on a valid/ready interface with a last-word marker.
- Checks on the fly that each frame is monotonic in the configured direction, and reports per-frame status plus a saturating error count.
- Sits directly after the pipeline sorter as its consumer and checker.

Parameters:
- `DATA_WIDTH`, 8, width of `sort_data` and `out_data`.
- `FRAME_LEN`, 8, words per frame (≥ 2).
- `FIFO_DEPTH`, 4, buffer entries (power of 2, ≥ 2).
- `DESCENDING`, 0, 0 = frame must be non-decreasing, 1 = non-increasing.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sort_val` in 1: upstream word valid.
- `sort_data` in `DATA_WIDTH`: upstream word.
- `sort_rdy` out 1: sink can accept a word.
- `out_val` out 1: downstream word valid.
- `out_data` out `DATA_WIDTH`: downstream word.
- `out_last` out 1: `out_data` is the final word of its frame.
- `out_rdy` in 1: downstream accepts.
- `frame_done` out 1: one-cycle pulse after a frame's last word is accepted.
- `frame_err` out 1: order-violation status, qualified by `frame_done`.
- `err_count` out 16: number of bad frames, saturating.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `rst` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
  - While `rst` is high at an edge, everything below is cleared.
- Reset values:
  - `sort_rdy` = 0 during reset; it becomes 1 the first cycle after `rst` deasserts.
  - `out_val`, `out_last`, `frame_done` and `frame_err` = 0.
  - `err_count` = 0.
  - FIFO empty, frame index = 0, previous-word register = 0, sticky error = 0.
- Reset mid-frame: the partial frame and all FIFO contents are discarded, and no `frame_done` is issued for the partial frame.
- Upstream accept:
  - An accept is `sort_val & sort_rdy` at an edge.
  - `sort_rdy` = !full, computed combinationally from the FIFO count.
  - There is no pass-through when full: a pop and a push cannot occur on the same edge while the FIFO is full.
  - `sort_data` is ignored when `sort_val` = 0.
- Frame FSM:
  - IDLE (index = 0) and COLLECT (index 1..`FRAME_LEN`-1).
  - On an accept in IDLE: store the word as prev, clear sticky error, index = 1, go to COLLECT. No comparison is made.
  - On an accept in COLLECT, the word is compared with prev:
    - Violation when `DESCENDING` = 0 and word < prev.
    - Violation when `DESCENDING` = 1 and word > prev.
    - Equal words are legal.
    - The sticky error is ORed with the violation, prev is updated, and index increments.
  - Index wrap: when the accepted word is word number `FRAME_LEN`-1, index returns to 0 and the FSM returns to IDLE.
- Frame completion:
  - On the edge that accepts the last word, the block registers `frame_done` = 1 and `frame_err` = (sticky | this word's violation). Both are visible in the following cycle for exactly one cycle, then return to 0.
  - In the same edge, `err_count` increments if `frame_err` is set; it saturates at `16'hFFFF`.
  - A new frame may start on the very next edge with no bubble; `frame_done` of frame N coexists with word 0 of frame N+1.
- FIFO:
  - Each entry holds {last flag, data}; the last flag is set for frame word `FRAME_LEN`-1.
  - `out_val` = !empty, and `out_data`/`out_last` come from the head entry.
  - Latency: a word accepted at edge k into an empty FIFO appears on `out_val` in cycle k+1.
  - A pop is `out_val & out_rdy`.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
  - A push and pop on the same edge with 1 entry leaves the count at 1 and the head advances.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - `out_data`/`out_last` hold stable while `out_val` = 1 and `out_rdy` = 0.
- Downstream stall: backpressure on `out_rdy` does not affect order checking; checking happens at accept time.

Test Plan:
- Basic ascending frame: release reset, `out_rdy` = 1, send 1,2,3,4,5,6,7,8 back-to-back.
  - `out_data` sequence 1..8 one cycle behind.
  - `out_last` only with 8.
  - `frame_done` pulse one cycle after accepting 8, with `frame_err` = 0.
  - `err_count` = 0.
- Violation and equal words: send 0x10,0x20,0x20,0x1F,0x30,0x40,0x50,0x60.
  - `frame_done` with `frame_err` = 1 and `err_count` = 1.
  - A following clean frame gives `frame_err` = 0 and `err_count` stays 1.
- Backpressure: `out_rdy` = 0, `sort_val` = 1 continuously.
  - Exactly 4 accepts, then `sort_rdy` = 0 and `out_data` stable at the first word.
  - Raise `out_rdy`: all 8 words drain in order with no loss or duplication.
- Back-to-back frames: 3 consecutive clean frames with no gaps.
  - 3 `frame_done` pulses spaced 8 cycles apart.
  - `out_last` asserted on every 8th output word.
- Reset mid-frame: accept 5 words, assert `rst` for 1 edge.
  - `out_val` = 0, no `frame_done`, `err_count` = 0.
  - A new 8-word frame is then treated as a fresh frame starting at index 0.
- `DESCENDING` = 1: send 0xC9,0xB0,0xB0,0x80,0x40,0x20,0x10,0x00.
  - `frame_err` = 0.
  - Swapping the last two words gives `frame_err` = 1.

Source files
------------

// File: rtl/sort_frame_sink_if.sv
// Handshake bundle between the pipeline sorter, this frame sink and the
// downstream consumer.
//   sort_val / sort_data / sort_rdy           : upstream word handshake
//   out_val / out_data / out_last / out_rdy   : downstream word handshake
// Modports:
//   slave  - the sink (takes sorter words, drives downstream words)
//   master - the surrounding environment (sorter + downstream consumer)
interface sort_frame_sink_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sort_val;
  logic [DATA_WIDTH-1:0] sort_data;
  logic                  sort_rdy;
  logic                  out_val;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_rdy;

  modport slave (
    input  sort_val, sort_data, out_rdy,
    output sort_rdy, out_val, out_data, out_last
  );

  modport master (
    output sort_val, sort_data, out_rdy,
    input  sort_rdy, out_val, out_data, out_last
  );
endinterface

// File: rtl/sort_frame_sink.sv
// Sorter output sink: accepts fixed-length frames of sorted words, buffers
// them in a small FIFO and forwards them downstream with a last-word marker.
// Each frame is checked at accept time for monotonic order (non-decreasing,
// or non-increasing when DESCENDING = 1); a per-frame status pulse and a
// saturating bad-frame counter are reported.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : sort_val/sort_data/sort_rdy in, out_val/out_data/out_last/out_rdy out
//   frame_done : one-cycle pulse after a frame's last word is accepted
//   frame_err  : order violation seen in that frame (valid with frame_done)
//   err_count  : number of bad frames, saturating at 16'hFFFF
module sort_frame_sink #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DESCENDING = 0
) (
  input  logic                clk,
  input  logic                rst,
  sort_frame_sink_if.slave    bus,
  output logic                frame_done,
  output logic                frame_err,
  output logic [15:0]         err_count
);

  localparam int IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]            state;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] prev;
  logic                  sticky;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

  logic accept;
  logic pop;
  logic viol;
  logic last_word;
  logic frame_bad;

  // Ready is forced low while reset is asserted so nothing is taken before
  // the FIFO state is known.
  assign bus.sort_rdy = !rst && (count != FULL_CNT);
  assign bus.out_val  = (count != '0);
  assign bus.out_data = mem[rd_ptr][DATA_WIDTH-1:0];
  assign bus.out_last = bus.out_val && mem[rd_ptr][DATA_WIDTH];

  assign accept    = bus.sort_val && bus.sort_rdy;
  assign pop       = bus.out_val && bus.out_rdy;
  assign viol      = (DESCENDING != 0) ? (bus.sort_data > prev)
                                       : (bus.sort_data < prev);
  assign last_word = (state == COLLECT) && (idx == LAST_IDX);
  assign frame_bad = sticky || viol;

  // Frame order checker
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      prev       <= '0;
      sticky     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (accept) begin
        prev <= bus.sort_data;
        if (state == IDLE) begin
          sticky <= 1'b0;
          idx    <= IW'(1);
          state  <= COLLECT;
        end else begin
          sticky <= frame_bad;
          if (last_word) begin
            idx        <= '0;
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_err  <= frame_bad;
            if (frame_bad && (err_count != '1))
              err_count <= err_count + 16'd1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= {last_word, bus.sort_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      if (accept && !pop)
        count <= count + (PW + 1)'(1);
      else if (pop && !accept)
        count <= count - (PW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_sort_frame_sink.sv
module tb_sort_frame_sink;

  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // index 0: ascending DUT, index 1: descending DUT
  logic       sval  [2];
  logic [7:0] sdata [2];
  logic       ordy  [2];
  logic       srdy  [2];
  logic       oval  [2];
  logic [7:0] odata [2];
  logic       olast [2];
  logic       fdone [2];
  logic       ferr  [2];
  logic [15:0] ecount [2];

  sort_frame_sink_if #(.DATA_WIDTH(8)) bus_a ();
  sort_frame_sink_if #(.DATA_WIDTH(8)) bus_d ();

  assign bus_a.sort_val  = sval[0];
  assign bus_a.sort_data = sdata[0];
  assign bus_a.out_rdy   = ordy[0];
  assign srdy[0]  = bus_a.sort_rdy;
  assign oval[0]  = bus_a.out_val;
  assign odata[0] = bus_a.out_data;
  assign olast[0] = bus_a.out_last;

  assign bus_d.sort_val  = sval[1];
  assign bus_d.sort_data = sdata[1];
  assign bus_d.out_rdy   = ordy[1];
  assign srdy[1]  = bus_d.sort_rdy;
  assign oval[1]  = bus_d.out_val;
  assign odata[1] = bus_d.out_data;
  assign olast[1] = bus_d.out_last;

  sort_frame_sink #(.DATA_WIDTH(8), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH), .DESCENDING(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .frame_done(fdone[0]), .frame_err(ferr[0]), .err_count(ecount[0])
  );

  sort_frame_sink #(.DATA_WIDTH(8), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH), .DESCENDING(1)) dut_d (
    .clk(clk), .rst(rst), .bus(bus_d),
    .frame_done(fdone[1]), .frame_err(ferr[1]), .err_count(ecount[1])
  );

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, id, $time, act, exp);
    end
  endtask

  // Per-DUT reference model: the FIFO is a plain queue of {last,data}, a frame
  // is judged only once all of its words are collected.
  for (genvar g = 0; g < 2; g++) begin : gm
    logic [8:0] mq [$];
    logic [7:0] cur [$];
    bit         errlog [$];
    int         done_cyc [$];
    bit         mvalid = 0;
    bit         edone  = 0;
    bit         eerr   = 0;
    int         ecnt   = 0;
    int         nacc   = 0;
    int         npop   = 0;
    int         cyc    = 0;

    always @(negedge clk) begin
      bit acc, pp, bad;
      cyc++;
      if (mvalid) begin
        chk("sort_rdy", g, srdy[g], (!rst && mq.size() < FIFO_DEPTH));
        chk("out_val", g, oval[g], (mq.size() != 0));
        if (mq.size() != 0) begin
          chk("out_data", g, odata[g], mq[0][7:0]);
          chk("out_last", g, olast[g], mq[0][8]);
        end
        chk("frame_done", g, fdone[g], edone);
        if (edone) chk("frame_err", g, ferr[g], eerr);
        chk("err_count", g, ecount[g], ecnt);
      end
      if (fdone[g]) done_cyc.push_back(cyc);

      if (rst) begin
        mq.delete();
        cur.delete();
        edone  = 0;
        eerr   = 0;
        ecnt   = 0;
        mvalid = 1;
      end else if (mvalid) begin
        acc = sval[g] && (mq.size() < FIFO_DEPTH);
        pp  = ordy[g] && (mq.size() != 0);
        edone = 0;
        if (pp) begin
          void'(mq.pop_front());
          npop++;
        end
        if (acc) begin
          nacc++;
          cur.push_back(sdata[g]);
          if (cur.size() == FRAME_LEN) begin
            bad = 0;
            for (int i = 1; i < FRAME_LEN; i++)
              if ((g == 1) ? (cur[i] > cur[i-1]) : (cur[i] < cur[i-1])) bad = 1;
            edone = 1;
            eerr  = bad;
            errlog.push_back(bad);
            if (bad && ecnt < 65535) ecnt++;
            cur.delete();
            mq.push_back({1'b1, sdata[g]});
          end else begin
            mq.push_back({1'b0, sdata[g]});
          end
        end
      end
    end
  end

  task automatic put(input int d, input logic [7:0] w);
    int n;
    logic r;
    sval[d]  = 1'b1;
    sdata[d] = w;
    n = 0;
    forever begin
      r = srdy[d];
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n > 100) begin
        vectors++;
        miscompares++;
        $display("FAIL put_timeout[%0d]: got no accept expected accept within 100 cycles", d);
        break;
      end
    end
  endtask

  task automatic frame(input int d, input logic [7:0] w [FRAME_LEN]);
    for (int i = 0; i < FRAME_LEN; i++) put(d, w[i]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] f_up   [FRAME_LEN] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] f_bad  [FRAME_LEN] = '{8'h10, 8'h20, 8'h20, 8'h1F, 8'h30, 8'h40, 8'h50, 8'h60};
  logic [7:0] f_bp   [FRAME_LEN] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
  logic [7:0] f_dn   [FRAME_LEN] = '{8'hC9, 8'hB0, 8'hB0, 8'h80, 8'h40, 8'h20, 8'h10, 8'h00};
  logic [7:0] f_dbad [FRAME_LEN] = '{8'hC9, 8'hB0, 8'hB0, 8'h80, 8'h40, 8'h20, 8'h00, 8'h10};

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int base, pbase, dbase, lbase;
    for (int i = 0; i < 2; i++) begin
      sval[i] = 1'b0; sdata[i] = '0; ordy[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("lit_rdy_after_rst", 0, srdy[0], 1);
    chk("lit_oval_after_rst", 0, oval[0], 0);
    chk("lit_errcnt_after_rst", 0, ecount[0], 0);
    #1;
    @(posedge clk); #1;

    // basic ascending frame
    frame(0, f_up);
    sval[0] = 1'b0;
    cycles(4);
    chk("lit_model_err_f0", 0, gm[0].errlog[0], 0);
    chk("lit_errcnt_f0", 0, ecount[0], 0);

    // violation with equal words, then a clean frame
    frame(0, f_bad);
    frame(0, f_up);
    sval[0] = 1'b0;
    cycles(4);
    chk("lit_model_err_f1", 0, gm[0].errlog[1], 1);
    chk("lit_model_err_f2", 0, gm[0].errlog[2], 0);
    chk("lit_errcnt_f2", 0, ecount[0], 1);

    // backpressure: FIFO fills after exactly four accepts
    ordy[0] = 1'b0;
    base  = gm[0].nacc;
    pbase = gm[0].npop;
    fork
      frame(0, f_bp);
    join_none
    cycles(10);
    chk("lit_bp_accepts", 0, gm[0].nacc - base, 4);
    chk("lit_bp_rdy", 0, srdy[0], 0);
    chk("lit_bp_head", 0, odata[0], 8'h11);
    ordy[0] = 1'b1;
    wait fork;
    sval[0] = 1'b0;
    cycles(8);
    chk("lit_bp_pops", 0, gm[0].npop - pbase, 8);
    chk("lit_bp_accepts_all", 0, gm[0].nacc - base, 8);

    // three back-to-back frames
    dbase = gm[0].done_cyc.size();
    frame(0, f_up);
    frame(0, f_bp);
    frame(0, f_up);
    sval[0] = 1'b0;
    cycles(4);
    chk("lit_b2b_done_count", 0, gm[0].done_cyc.size() - dbase, 3);
    if (gm[0].done_cyc.size() >= dbase + 3) begin
      chk("lit_b2b_gap1", 0, gm[0].done_cyc[dbase+1] - gm[0].done_cyc[dbase], 8);
      chk("lit_b2b_gap2", 0, gm[0].done_cyc[dbase+2] - gm[0].done_cyc[dbase+1], 8);
    end

    // reset in the middle of a frame
    for (int i = 0; i < 5; i++) put(0, 8'h50 + 8'(i * 16));
    sval[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("lit_midrst_oval", 0, oval[0], 0);
    chk("lit_midrst_done", 0, fdone[0], 0);
    chk("lit_midrst_errcnt", 0, ecount[0], 0);
    cycles(3);
    lbase = gm[0].errlog.size();
    frame(0, f_up);
    sval[0] = 1'b0;
    cycles(4);
    chk("lit_fresh_frames", 0, gm[0].errlog.size() - lbase, 1);
    chk("lit_fresh_err", 0, gm[0].errlog[lbase], 0);
    chk("lit_fresh_errcnt", 0, ecount[0], 0);

    // descending instance
    frame(1, f_dn);
    sval[1] = 1'b0;
    cycles(4);
    frame(1, f_dbad);
    sval[1] = 1'b0;
    cycles(4);
    chk("lit_desc_err0", 1, gm[1].errlog[0], 0);
    chk("lit_desc_err1", 1, gm[1].errlog[1], 1);
    chk("lit_desc_errcnt", 1, ecount[1], 1);

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
